// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bus: hazard/branch/memory inputs from the datapath and the
// stage-register, PC and counter controls driven back to it.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic [31:0]      ex_branch_target;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_we;
  logic             pc_sel;
  logic [31:0]      pc_target;
  logic             if_id_valid;
  logic             id_ex_valid;
  logic             ex_mem_valid;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, mem_req, mem_ready,
    input  pc_we, pc_sel, pc_target, if_id_valid, id_ex_valid, ex_mem_valid,
           if_id_flush, id_ex_flush, mem_wb_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, mem_req, mem_ready,
    output pc_we, pc_sel, pc_target, if_id_valid, id_ex_valid, ex_mem_valid,
           if_id_flush, id_ex_flush, mem_wb_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use stalls,
// registered branch redirects, data-memory wait freezes and perf counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  state_t           state;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic freeze;
  logic lu_hazard;

  // In MEM_WAIT the access is already outstanding, so only ready matters.
  assign freeze = (state == MEM_WAIT) ? ~bus.mem_ready
                                      : (bus.mem_req & ~bus.mem_ready);

  assign lu_hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                     ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    bus.pc_we        = 1'b1;
    bus.pc_sel       = 1'b0;
    bus.pc_target    = redirect_pc;
    bus.if_id_valid  = 1'b1;
    bus.id_ex_valid  = 1'b1;
    bus.ex_mem_valid = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.mem_wb_flush = 1'b0;

    if (reset) begin
      bus.pc_we        = 1'b0;
      bus.pc_target    = 32'd0;
      bus.if_id_valid  = 1'b0;
      bus.id_ex_valid  = 1'b0;
      bus.ex_mem_valid = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.mem_wb_flush = 1'b1;
    end else if (freeze) begin
      bus.pc_we        = 1'b0;
      bus.if_id_valid  = 1'b0;
      bus.id_ex_valid  = 1'b0;
      bus.ex_mem_valid = 1'b0;
      bus.mem_wb_flush = 1'b1;
    end else if (state == REDIRECT) begin
      bus.pc_sel      = 1'b1;
      bus.if_id_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      bus.pc_we       = 1'b0;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (lu_hazard) begin
      bus.pc_we       = 1'b0;
      bus.if_id_valid = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state       <= RUN;
      redirect_pc <= 32'd0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (freeze) begin
      // A frozen redirect keeps its state and target until the freeze clears.
      if (state != REDIRECT) state <= MEM_WAIT;
      stall_cnt <= stall_cnt + 1'b1;
    end else if (state == REDIRECT) begin
      state <= RUN;
    end else if (bus.ex_branch_taken) begin
      state       <= REDIRECT;
      redirect_pc <= bus.ex_branch_target;
      flush_cnt   <= flush_cnt + 1'b1;
    end else begin
      state <= RUN;
      if (lu_hazard) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by
// random traffic, all compared against an event-level reference model.
module tb_pipeline_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipeline_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: what is pending, not how the RTL encodes it.
  bit          m_redirect_pending;
  bit          m_mem_outstanding;
  logic [31:0] m_target;
  int          m_stalls;
  int          m_flushes;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                       logic [4:0] rd, logic ld, logic br, logic [31:0] tgt,
                       logic mreq, logic mrdy);
    reset                = rst;
    bus.id_rs1           = rs1;
    bus.id_rs2           = rs2;
    bus.id_use_rs1       = u1;
    bus.id_use_rs2       = u2;
    bus.ex_rd            = rd;
    bus.ex_mem_read      = ld;
    bus.ex_branch_taken  = br;
    bus.ex_branch_target = tgt;
    bus.mem_req          = mreq;
    bus.mem_ready        = mrdy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
  endtask

  // Compare mid-cycle, then advance the model across the rising edge.
  task automatic tick(string tag);
    logic [7:0]  exp_ctl;
    logic [31:0] exp_tgt;
    bit          frz;
    bit          hazard;
    #4;
    hazard = bus.ex_mem_read && bus.ex_rd != 0 &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    frz = m_mem_outstanding ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);
    exp_tgt = reset ? 32'h0 : m_target;
    // {pc_we, pc_sel, if_id_valid, id_ex_valid, ex_mem_valid, if_id_flush, id_ex_flush, mem_wb_flush}
    if (reset)                    exp_ctl = 8'b0000_0111;
    else if (frz)                 exp_ctl = 8'b0000_0001;
    else if (m_redirect_pending)  exp_ctl = 8'b1111_1100;
    else if (bus.ex_branch_taken) exp_ctl = 8'b0011_1110;
    else if (hazard)              exp_ctl = 8'b0001_1010;
    else                          exp_ctl = 8'b1011_1000;

    chk({tag, ".ctl"}, {56'd0, bus.pc_we, bus.pc_sel, bus.if_id_valid, bus.id_ex_valid,
        bus.ex_mem_valid, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush}, {56'd0, exp_ctl});
    chk({tag, ".pc_target"}, {32'd0, bus.pc_target}, {32'd0, exp_tgt});
    if (!reset) begin
      chk({tag, ".stall_cnt"}, {60'd0, bus.stall_cnt}, 64'(m_stalls % 16));
      chk({tag, ".flush_cnt"}, {60'd0, bus.flush_cnt}, 64'(m_flushes % 16));
    end

    @(posedge clk);
    if (reset) begin
      m_redirect_pending = 0; m_mem_outstanding = 0; m_target = 0;
      m_stalls = 0; m_flushes = 0;
    end else if (frz) begin
      m_stalls++;
      if (!m_redirect_pending) m_mem_outstanding = 1;
    end else if (m_redirect_pending) begin
      m_redirect_pending = 0;
    end else if (bus.ex_branch_taken) begin
      m_target = bus.ex_branch_target;
      m_redirect_pending = 1;
      m_mem_outstanding = 0;
      m_flushes++;
    end else begin
      m_mem_outstanding = 0;
      if (hazard) m_stalls++;
    end
    #1;
  endtask

  initial begin
    m_redirect_pending = 0; m_mem_outstanding = 0; m_target = 0;
    m_stalls = 0; m_flushes = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    @(posedge clk); #1;
    tick("reset0");
    tick("reset1");

    // Load-use: one stall cycle, then no hazard when rd=0 or rs1 unused.
    drive(0, 5, 0, 1, 0, 5, 1, 0, 32'h0, 0, 1); tick("lu");
    chk("lu.stall_cnt_after", {60'd0, bus.stall_cnt}, 64'd1);
    drive(0, 0, 0, 1, 0, 0, 1, 0, 32'h0, 0, 1); tick("lu_rd0");
    drive(0, 5, 0, 0, 0, 5, 1, 0, 32'h0, 0, 1); tick("lu_nouse");
    drive(0, 0, 7, 0, 1, 7, 1, 0, 32'h0, 0, 1); tick("lu_rs2");

    // Taken branch: T then T+1 redirect.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0100, 0, 1); tick("br_T");
    idle(); tick("br_T1");
    chk("br.flush_cnt", {60'd0, bus.flush_cnt}, 64'd1);
    idle(); tick("br_T2");

    // Memory wait of 3 cycles, exit on ready.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0); tick("mw0");
    tick("mw1");
    tick("mw2");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1); tick("mw_ready");
    idle(); tick("mw_after");

    // Branch with load-use: branch wins, no stall.
    drive(0, 5, 0, 1, 0, 5, 1, 1, 32'h0000_0200, 0, 1); tick("br_lu_T");
    idle(); tick("br_lu_T1");

    // Branch with freeze: redirect waits until the freeze clears.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0300, 1, 0); tick("br_frz0");
    tick("br_frz1");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0300, 1, 1); tick("br_frz_T");
    idle(); tick("br_frz_T1");

    // Freeze during REDIRECT holds the target.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0400, 0, 1); tick("rd_frz_T");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0); tick("rd_frz_hold");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1); tick("rd_frz_apply");
    idle(); tick("rd_frz_after");

    // Reset in the middle of REDIRECT.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0500, 0, 1); tick("rst_br_T");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1); tick("rst_mid0");
    tick("rst_mid1");
    idle(); tick("rst_after");
    chk("rst.stall_cnt", {60'd0, bus.stall_cnt}, 64'd0);
    chk("rst.flush_cnt", {60'd0, bus.flush_cnt}, 64'd0);

    // 17 load-use stalls wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      drive(0, 9, 0, 1, 0, 9, 1, 0, 32'h0, 0, 1);
      tick("lu_wrap");
    end
    chk("wrap.stall_cnt", {60'd0, bus.stall_cnt}, 64'd1);

    // Random traffic with small register indices to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), ($urandom_range(0, 5) == 0), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage core. It drives the `valid` (advance) and `flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable and redirect. It resolves three event classes:
- load-use stalls;
- taken branch/jump redirects, with a registered redirect cycle;
- data-memory wait stalls.

It also keeps stall and flush performance counters.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` input 1: core clock. All state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` input 5 each: source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` input 1 each: the ID instruction actually reads rs1 / rs2.
- `ex_rd` input 5: destination register of the instruction in EX.
- `ex_mem_read` input 1: the instruction in EX is a load.
- `ex_branch_taken` input 1: a branch/jump resolved taken in EX this cycle.
- `ex_branch_target` input 32: its target PC.
- `mem_req` input 1: the MEM-stage instruction accesses data memory this cycle.
- `mem_ready` input 1: data memory completes the access this cycle.
- `pc_we` output 1: PC register update enable.
- `pc_sel` output 1: 1 selects `pc_target`, 0 selects the sequential PC.
- `pc_target` output 32: redirect PC (the registered `redirect_pc`).
- `if_id_valid`, `id_ex_valid`, `ex_mem_valid` output 1 each: stage register load enable. 0 holds the register.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` output 1 each: clear the stage register to a bubble.
- `stall_cnt` output CNT_W: count of stall cycles.
- `flush_cnt` output CNT_W: count of redirect events.

## Operation
Registered state:
- `state`, one of `RUN`, `MEM_WAIT`, `REDIRECT`.
- `redirect_pc`, 32 bits.
- `stall_cnt` and `flush_cnt`.

Outputs are combinational from the registered state and current inputs.

Derived terms:
- `freeze` = `mem_req & ~mem_ready` in `RUN` or `REDIRECT`, or `~mem_ready` in `MEM_WAIT`.
- `lu_hazard` = `ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.

Default, no event: `pc_we` = 1, `pc_sel` = 0, all `*_valid` = 1, all flushes = 0.

Priority per cycle, highest first:
1. `freeze`:
   - `pc_we` = 0.
   - `if_id_valid`, `id_ex_valid`, `ex_mem_valid` all = 0.
   - `mem_wb_flush` = 1, inserting a bubble into WB.
   - No other flush.
   - Next `state` = `MEM_WAIT`, except when the current state is `REDIRECT`: it stays `REDIRECT` and `redirect_pc` is held.
2. `state == REDIRECT`:
   - `pc_we` = 1, `pc_sel` = 1.
   - `if_id_flush` = 1, killing the wrong-path fetch.
   - Next `state` = `RUN`.
   - `ex_branch_taken` and `lu_hazard` are ignored, since EX/ID hold only bubbles.
3. `ex_branch_taken`:
   - `redirect_pc` <= `ex_branch_target`.
   - `if_id_flush` = 1, `id_ex_flush` = 1, `pc_we` = 0.
   - Next `state` = `REDIRECT`.
   - `flush_cnt` += 1.
   - Overrides `lu_hazard`.
4. `lu_hazard`:
   - `pc_we` = 0, `if_id_valid` = 0 (hold), `id_ex_flush` = 1 (bubble).
   - `state` unchanged.

State transitions:
- `MEM_WAIT` exits to `RUN` in the cycle `mem_ready` = 1. That cycle is non-frozen and is evaluated by rules 3–4.
- `stall_cnt` += 1 in every cycle where `freeze` or a rule-4 stall is applied.

Counter rules:
- Both counters wrap modulo 2^CNT_W.
- No saturation.

## Timing
- Reset, sampled at the rising edge: `state` = `RUN`, `redirect_pc` = 0, `stall_cnt` = 0, `flush_cnt` = 0.
- While `reset` = 1, outputs are forced to:
  - `pc_we` = 0, `pc_sel` = 0;
  - all `*_valid` = 0;
  - all flushes = 1;
  - `pc_target` = 0.
- Reset mid-`MEM_WAIT` or mid-`REDIRECT` discards the pending event. The first cycle after reset is `RUN`.
- Load-use penalty is 1 cycle. The dependent instruction stays in ID for exactly 1 extra cycle, then advances with forwarding from MEM.
- Taken-branch penalty is 3 cycles, with the branch in EX at cycle T:
  - T flushes branch+4 and branch+8.
  - T+1 loads `pc_target` and flushes the fetch of branch+8.
  - The target instruction is fetched in T+2.
- A memory stall of N cycles, where `mem_ready` is low for N consecutive cycles after `mem_req`, freezes the pipe for exactly N cycles and adds N to `stall_cnt`.
- `freeze` arriving in `REDIRECT` delays the redirect. `pc_target` stays stable until the redirect is applied.

## Test plan
- **Load-use:** ld x5 in EX, ID uses rs1 = 5 with `id_use_rs1` = 1.
  - Required: one cycle with `pc_we` = 0, `if_id_valid` = 0, `id_ex_flush` = 1.
  - `stall_cnt` 0→1.
  - Same stimulus with `ex_rd` = 0, or with `id_use_rs1` = 0: no stall.
- **Taken branch:** `ex_branch_taken` = 1, target `0x0000_0100`.
  - Cycle T: `if_id_flush` = 1, `id_ex_flush` = 1, `pc_we` = 0.
  - Cycle T+1: `pc_sel` = 1, `pc_target` = `0x100`, `pc_we` = 1, `if_id_flush` = 1.
  - `flush_cnt` = 1.
- **Memory wait:** `mem_req` = 1, `mem_ready` low for 3 cycles.
  - Required: 3 frozen cycles (all `*_valid` = 0, `mem_wb_flush` = 1), state back to `RUN` on the ready cycle.
  - `stall_cnt` = 3.
- **Simultaneous events:**
  - Branch taken together with `lu_hazard`: the branch wins and no stall is counted.
  - Branch taken together with `freeze`: no redirect until the freeze clears, then the T/T+1 sequence above.
- **Reset mid-event:** assert `reset` during `REDIRECT`.
  - Required: forced outputs while `reset` = 1.
  - After reset: `state` = `RUN`, `pc_sel` = 0, counters 0.
- **Counter wrap:** with `CNT_W` = 4, 17 load-use stalls → `stall_cnt` = 1.
